// File: rtl/mgmt_bus_arbiter.sv
// Two-master round-robin arbiter for the 16-bit-address / 8-bit-data management register bus.
// Tracks the single outstanding read and answers it with 8'hFF if the slave never responds.
module mgmt_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    output logic        m0_grant,
    input  logic        m0_rd_en,
    input  logic [15:0] m0_rd_addr,
    output logic        m0_rd_valid,
    output logic [7:0]  m0_rd_data,
    input  logic        m0_wr_en,
    input  logic [15:0] m0_wr_addr,
    input  logic [7:0]  m0_wr_data,

    input  logic        m1_req,
    output logic        m1_grant,
    input  logic        m1_rd_en,
    input  logic [15:0] m1_rd_addr,
    output logic        m1_rd_valid,
    output logic [7:0]  m1_rd_data,
    input  logic        m1_wr_en,
    input  logic [15:0] m1_wr_addr,
    input  logic [7:0]  m1_wr_data,

    output logic        s_rd_en,
    output logic [15:0] s_rd_addr,
    input  logic        s_rd_valid,
    input  logic [7:0]  s_rd_data,
    output logic        s_wr_en,
    output logic [15:0] s_wr_addr,
    output logic [7:0]  s_wr_data,

    output logic        cmd_dropped,
    output logic        stray_valid,
    output logic        rd_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OWN0   = 3'd1,
        OWN1   = 3'd2,
        DRAIN0 = 3'd3,
        DRAIN1 = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last_owner;
    logic             w_last_next;

    logic             r_rd_pending;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic             r_m0_grant, r_m1_grant;
    logic             r_m0_rd_valid, r_m1_rd_valid;
    logic [7:0]       r_m0_rd_data, r_m1_rd_data;
    logic             r_s_rd_en, r_s_wr_en;
    logic [15:0]      r_s_rd_addr, r_s_wr_addr;
    logic [7:0]       r_s_wr_data;
    logic             r_cmd_dropped, r_stray_valid, r_rd_timeout;

    logic             w_own0, w_own1;
    logic             w_fwd_rd, w_fwd_wr;
    logic             w_drop;
    logic             w_resp, w_tmo, w_done;
    logic             w_pend_next;
    logic [15:0]      w_rd_addr, w_wr_addr;
    logic [7:0]       w_wr_data;
    logic [7:0]       w_rsp_data;

    // DRAIN states keep forwarding so the owner can still complete its read.
    assign w_own0 = (r_state == OWN0) || (r_state == DRAIN0);
    assign w_own1 = (r_state == OWN1) || (r_state == DRAIN1);

    assign w_fwd_rd = (w_own0 && m0_rd_en) || (w_own1 && m1_rd_en);
    assign w_fwd_wr = (w_own0 && m0_wr_en) || (w_own1 && m1_wr_en);
    assign w_drop   = (!w_own0 && (m0_rd_en || m0_wr_en)) ||
                      (!w_own1 && (m1_rd_en || m1_wr_en));

    assign w_rd_addr = w_own1 ? m1_rd_addr : m0_rd_addr;
    assign w_wr_addr = w_own1 ? m1_wr_addr : m0_wr_addr;
    assign w_wr_data = w_own1 ? m1_wr_data : m0_wr_data;

    // A real slave response in the final cycle beats the synthetic one.
    assign w_resp      = r_rd_pending && s_rd_valid;
    assign w_tmo       = r_rd_pending && !s_rd_valid && (r_tmo_cnt == CNT_LAST);
    assign w_done      = w_resp || w_tmo;
    assign w_pend_next = w_fwd_rd || (r_rd_pending && !w_done);
    assign w_rsp_data  = w_resp ? s_rd_data : 8'hFF;

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last_owner;
        case (r_state)
            IDLE: begin
                if (m0_req && (!m1_req || r_last_owner)) begin
                    w_state_next = OWN0;
                    w_last_next  = 1'b0;
                end else if (m1_req) begin
                    w_state_next = OWN1;
                    w_last_next  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_req) w_state_next = w_pend_next ? DRAIN0 : IDLE;
            end
            OWN1: begin
                if (!m1_req) w_state_next = w_pend_next ? DRAIN1 : IDLE;
            end
            DRAIN0, DRAIN1: begin
                if (!w_pend_next) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_owner  <= 1'b1;
            r_rd_pending  <= 1'b0;
            r_tmo_cnt     <= '0;
            r_m0_grant    <= 1'b0;
            r_m1_grant    <= 1'b0;
            r_m0_rd_valid <= 1'b0;
            r_m1_rd_valid <= 1'b0;
            r_m0_rd_data  <= '0;
            r_m1_rd_data  <= '0;
            r_s_rd_en     <= 1'b0;
            r_s_rd_addr   <= '0;
            r_s_wr_en     <= 1'b0;
            r_s_wr_addr   <= '0;
            r_s_wr_data   <= '0;
            r_cmd_dropped <= 1'b0;
            r_stray_valid <= 1'b0;
            r_rd_timeout  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_owner <= w_last_next;
            // Grants follow the next state so they rise one cycle after req is sampled.
            r_m0_grant   <= (w_state_next == OWN0) || (w_state_next == DRAIN0);
            r_m1_grant   <= (w_state_next == OWN1) || (w_state_next == DRAIN1);

            r_s_rd_en <= w_fwd_rd;
            if (w_fwd_rd) r_s_rd_addr <= w_rd_addr;
            r_s_wr_en <= w_fwd_wr;
            if (w_fwd_wr) begin
                r_s_wr_addr <= w_wr_addr;
                r_s_wr_data <= w_wr_data;
            end

            r_m0_rd_valid <= w_done && w_own0;
            r_m1_rd_valid <= w_done && w_own1;
            if (w_done && w_own0) r_m0_rd_data <= w_rsp_data;
            if (w_done && w_own1) r_m1_rd_data <= w_rsp_data;

            r_cmd_dropped <= w_drop;
            r_stray_valid <= s_rd_valid && !r_rd_pending;
            r_rd_timeout  <= w_tmo;

            r_rd_pending <= w_pend_next;
            if (w_fwd_rd)
                r_tmo_cnt <= '0;
            else if (r_rd_pending && !w_done)
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            else
                r_tmo_cnt <= '0;
        end
    end

    assign m0_grant    = r_m0_grant;
    assign m1_grant    = r_m1_grant;
    assign m0_rd_valid = r_m0_rd_valid;
    assign m1_rd_valid = r_m1_rd_valid;
    assign m0_rd_data  = r_m0_rd_data;
    assign m1_rd_data  = r_m1_rd_data;
    assign s_rd_en     = r_s_rd_en;
    assign s_rd_addr   = r_s_rd_addr;
    assign s_wr_en     = r_s_wr_en;
    assign s_wr_addr   = r_s_wr_addr;
    assign s_wr_data   = r_s_wr_data;
    assign cmd_dropped = r_cmd_dropped;
    assign stray_valid = r_stray_valid;
    assign rd_timeout  = r_rd_timeout;

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// Directed bench for mgmt_bus_arbiter: an ownership/read-tracking model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_mgmt_bus_arbiter;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, rd_en, wr_en;
    logic [1:0][15:0] rd_addr, wr_addr;
    logic [1:0][7:0]  wr_data;
    logic        s_rd_valid;
    logic [7:0]  s_rd_data;

    wire         m0_grant, m1_grant, m0_rd_valid, m1_rd_valid;
    wire [7:0]   m0_rd_data, m1_rd_data;
    wire         s_rd_en, s_wr_en;
    wire [15:0]  s_rd_addr, s_wr_addr;
    wire [7:0]   s_wr_data;
    wire         cmd_dropped, stray_valid, rd_timeout;

    int n_chk = 0;
    int n_err = 0;

    mgmt_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_grant(m0_grant),
        .m0_rd_en(rd_en[0]), .m0_rd_addr(rd_addr[0]),
        .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
        .m0_wr_en(wr_en[0]), .m0_wr_addr(wr_addr[0]), .m0_wr_data(wr_data[0]),
        .m1_req(req[1]), .m1_grant(m1_grant),
        .m1_rd_en(rd_en[1]), .m1_rd_addr(rd_addr[1]),
        .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
        .m1_wr_en(wr_en[1]), .m1_wr_addr(wr_addr[1]), .m1_wr_data(wr_data[1]),
        .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr),
        .s_rd_valid(s_rd_valid), .s_rd_data(s_rd_data),
        .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .cmd_dropped(cmd_dropped), .stray_valid(stray_valid), .rd_timeout(rd_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: owner index (-1 = nobody), whether the owner has released but still waits
    // on a read, whether a read is outstanding and how long it has waited.
    int  own = -1, last = 1, age = 0;
    bit  pend = 0, draining = 0, started = 0;
    logic [1:0]      e_grant = '0, e_rd_valid = '0;
    logic [1:0][7:0] e_rd_data = '0;
    logic        e_s_rd_en = 0, e_s_wr_en = 0, e_drop = 0, e_stray = 0, e_tmo = 0;
    logic [15:0] e_s_rd_addr = '0, e_s_wr_addr = '0;
    logic [7:0]  e_s_wr_data = '0;

    task automatic model_step();
        int win;
        bit fwd_r, fwd_w, done_real, done_tmo;
        started = 1'b1;
        if (!rst_n) begin
            own = -1; last = 1; age = 0; pend = 0; draining = 0;
            e_grant = '0; e_rd_valid = '0; e_s_rd_en = 0; e_s_wr_en = 0;
            e_drop = 0; e_stray = 0; e_tmo = 0;
            return;
        end
        fwd_r = (own >= 0) && rd_en[own[0]];
        fwd_w = (own >= 0) && wr_en[own[0]];
        e_drop = 0;
        for (int m = 0; m < 2; m++)
            if ((own != m) && (rd_en[m[0]] || wr_en[m[0]])) e_drop = 1;
        e_s_rd_en = fwd_r;
        if (fwd_r) e_s_rd_addr = rd_addr[own[0]];
        e_s_wr_en = fwd_w;
        if (fwd_w) begin
            e_s_wr_addr = wr_addr[own[0]];
            e_s_wr_data = wr_data[own[0]];
        end
        e_stray   = s_rd_valid && !pend;
        done_real = pend && s_rd_valid;
        done_tmo  = pend && !s_rd_valid && (age == T - 1);
        e_tmo     = done_tmo;
        e_rd_valid = '0;
        if ((done_real || done_tmo) && own >= 0) begin
            e_rd_valid[own[0]] = 1'b1;
            e_rd_data[own[0]]  = done_real ? s_rd_data : 8'hFF;
        end
        if (fwd_r) begin
            pend = 1; age = 0;
        end else if (pend && !(done_real || done_tmo)) begin
            age++;
        end else begin
            pend = 0; age = 0;
        end
        if (own < 0) begin
            win = -1;
            if (req[0] && req[1]) win = 1 - last;
            else if (req[0])      win = 0;
            else if (req[1])      win = 1;
            if (win >= 0) begin
                own = win; last = win; draining = 0;
            end
        end else if (draining || !req[own[0]]) begin
            if (pend) draining = 1;
            else begin
                own = -1; draining = 0;
            end
        end
        e_grant[0] = (own == 0);
        e_grant[1] = (own == 1);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m0_grant", 32'(m0_grant), 32'(e_grant[0]));
            chk("m1_grant", 32'(m1_grant), 32'(e_grant[1]));
            chk("m0_rd_valid", 32'(m0_rd_valid), 32'(e_rd_valid[0]));
            chk("m1_rd_valid", 32'(m1_rd_valid), 32'(e_rd_valid[1]));
            if (e_rd_valid[0]) chk("m0_rd_data", 32'(m0_rd_data), 32'(e_rd_data[0]));
            if (e_rd_valid[1]) chk("m1_rd_data", 32'(m1_rd_data), 32'(e_rd_data[1]));
            chk("s_rd_en", 32'(s_rd_en), 32'(e_s_rd_en));
            if (e_s_rd_en) chk("s_rd_addr", 32'(s_rd_addr), 32'(e_s_rd_addr));
            chk("s_wr_en", 32'(s_wr_en), 32'(e_s_wr_en));
            if (e_s_wr_en) begin
                chk("s_wr_addr", 32'(s_wr_addr), 32'(e_s_wr_addr));
                chk("s_wr_data", 32'(s_wr_data), 32'(e_s_wr_data));
            end
            chk("cmd_dropped", 32'(cmd_dropped), 32'(e_drop));
            chk("stray_valid", 32'(stray_valid), 32'(e_stray));
            chk("rd_timeout", 32'(rd_timeout), 32'(e_tmo));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; rd_en = '0; wr_en = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        s_rd_valid = 1'b0; s_rd_data = '0;
        step(); step();
        chk("rst_grants", 32'({m1_grant, m0_grant}), 32'd0);
        chk("rst_strobes", 32'({s_rd_en, s_wr_en, cmd_dropped, stray_valid, rd_timeout}), 32'd0);
        chk("rst_rd_data", 32'({m1_rd_data, m0_rd_data}), 32'd0);
        rst_n = 1'b1;

        // M0 alone: read 0x0010, slave answers 0x5A
        req[0] = 1; step();
        chk("t1_grant0", 32'(m0_grant), 32'd1);
        rd_en[0] = 1; rd_addr[0] = 16'h0010; step();
        chk("t1_s_rd_addr", 32'({s_rd_en, s_rd_addr}), 32'h1_0010);
        rd_en[0] = 0; step(); step(); step();
        s_rd_valid = 1; s_rd_data = 8'h5A; step();
        chk("t1_rd_data", 32'({m0_rd_valid, m0_rd_data}), 32'h1_5A);
        s_rd_valid = 0; req[0] = 0; step();
        chk("t1_release", 32'(m0_grant), 32'd0);
        step();

        // Tie from reset, release with one idle cycle, alternation
        rst_n = 0; step(); rst_n = 1;
        req = 2'b11; step();
        chk("t2_tie_m0", 32'({m1_grant, m0_grant}), 32'b01);
        req[0] = 0; step();
        chk("t2_idle_gap", 32'({m1_grant, m0_grant}), 32'b00);
        step();
        chk("t2_m1_grant", 32'({m1_grant, m0_grant}), 32'b10);
        req[1] = 0; step();
        req = 2'b11; step();
        chk("t2_alternate", 32'({m1_grant, m0_grant}), 32'b01);
        req = 2'b00; step(); step();

        // Non-owner write dropped while owner write forwarded
        req[0] = 1; step();
        req[1] = 1; step();
        wr_en = 2'b11;
        wr_addr[1] = 16'h0100; wr_data[1] = 8'h33;
        wr_addr[0] = 16'h0200; wr_data[0] = 8'hAA;
        step();
        chk("t3_owner_wr", 32'({s_wr_en, s_wr_addr, s_wr_data}), 32'h1_0200_AA);
        chk("t3_dropped", 32'(cmd_dropped), 32'd1);
        wr_en = 2'b00; step();
        chk("t3_drop_pulse", 32'(cmd_dropped), 32'd0);

        // Release with a read pending: drain, then hand over to waiting M1
        rd_en[0] = 1; rd_addr[0] = 16'h0020; step();
        rd_en[0] = 0; req[0] = 0; step();
        chk("t4_drain_grant", 32'({m1_grant, m0_grant}), 32'b01);
        step();
        chk("t4_drain_hold", 32'({m1_grant, m0_grant}), 32'b01);
        s_rd_valid = 1; s_rd_data = 8'h77; step();
        chk("t4_drain_done", 32'({m1_grant, m0_grant, m0_rd_valid, m0_rd_data}), 32'h0_1_77);
        s_rd_valid = 0; step();
        chk("t4_m1_after", 32'(m1_grant), 32'd1);
        req[1] = 0; step(); step();

        // Dead read: synthetic 0xFF after T cycles, late response is stray
        req[0] = 1; step();
        rd_en[0] = 1; rd_addr[0] = 16'h0030; step();
        rd_en[0] = 0;
        for (int i = 0; i < T - 1; i++) step();
        chk("t5_not_yet", 32'({m0_rd_valid, rd_timeout}), 32'd0);
        step();
        chk("t5_timeout", 32'({m0_rd_valid, rd_timeout, m0_rd_data}), 32'h3_FF);
        step();
        s_rd_valid = 1; s_rd_data = 8'h12; step();
        chk("t5_stray", 32'({stray_valid, m0_rd_valid}), 32'b10);
        s_rd_valid = 0; req[0] = 0; step(); step();

        // Reset during an M1 read; the slave's reply becomes stray
        req[1] = 1; step();
        rd_en[1] = 1; rd_addr[1] = 16'h0040; step();
        rd_en[1] = 0; req[1] = 0; rst_n = 0; step();
        chk("t6_rst_clear", 32'({m1_grant, m0_grant, s_rd_en, s_wr_en}), 32'd0);
        rst_n = 1; s_rd_valid = 1; s_rd_data = 8'h99; step();
        chk("t6_stray", 32'({stray_valid, m1_rd_valid}), 32'b10);
        s_rd_valid = 0; step();

        // Strobe with no owner is dropped
        rd_en[0] = 1; rd_addr[0] = 16'h0050; step();
        chk("t7_idle_drop", 32'({cmd_dropped, s_rd_en}), 32'b10);
        rd_en[0] = 0; step();

        // Simultaneous owner rd+wr; real data arriving on the last cycle beats the timeout
        req[0] = 1; step();
        rd_en[0] = 1; rd_addr[0] = 16'h0060;
        wr_en[0] = 1; wr_addr[0] = 16'h0300; wr_data[0] = 8'h5C; step();
        chk("t8_rd_and_wr", 32'({s_rd_en, s_wr_en, s_rd_addr}), 32'h3_0060);
        rd_en[0] = 0; wr_en[0] = 0;
        for (int i = 0; i < T - 1; i++) step();
        s_rd_valid = 1; s_rd_data = 8'h3C; step();
        chk("t8_edge_real", 32'({m0_rd_valid, rd_timeout, m0_rd_data}), 32'h2_3C);
        s_rd_valid = 0; req[0] = 0; step(); step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mgmt_bus_arbiter.md
Name: mgmt_bus_arbiter

Overview:
- Two-master arbiter for the 16-bit-address / 8-bit-data management register bus (rd_en/rd_addr/rd_valid/rd_data, wr_en/wr_addr/wr_data).
- Lets the simulation management bridge and a second master (e.g. QSPI or Ethernet management) share a single register-space slave.
- Uses request/grant ownership with round-robin fairness, tracks the outstanding read, and times out dead reads so a master never hangs.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a forwarded read may wait for slave rd_valid before a synthetic response is generated (≥2).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- mN_req (N=0,1)  in  1  master requests bus ownership; held high for the whole transaction/burst.
- mN_grant  out  1  master owns bus.
- mN_rd_en  in  1  read strobe, honoured only while granted.
- mN_rd_addr  in  16  read address.
- mN_rd_valid  out  1  read data valid pulse.
- mN_rd_data  out  8  read data.
- mN_wr_en  in  1  write strobe, honoured only while granted.
- mN_wr_addr  in  16  write address.
- mN_wr_data  in  8  write data.
- s_rd_en  out  1  to slave.
- s_rd_addr  out  16  to slave.
- s_rd_valid  in  1  from slave.
- s_rd_data  in  8  from slave.
- s_wr_en  out  1  to slave.
- s_wr_addr  out  16  to slave.
- s_wr_data  out  8  to slave.
- cmd_dropped  out  1  pulse: strobe from a non-granted master discarded.
- stray_valid  out  1  pulse: s_rd_valid with no read pending.
- rd_timeout  out  1  pulse: synthetic read response issued.

Behaviour:
- All outputs registered. Under reset (rst_n low at posedge) every output is 0, state=IDLE, rd_pending=0, timeout counter=0, last_owner=1 (so M0 wins the first tie).
- States:
  - IDLE: no grants.
  - OWN0 / OWN1: grant held.
  - DRAIN0 / DRAIN1: owner has dropped req but a read is still pending; grant stays high, owner's strobes still forwarded.
- IDLE arbitration:
  - Only one req high: that master wins.
  - Both high: the master != last_owner wins.
  - Next state OWNn; mN_grant high the cycle after req is sampled. Winner's index is stored in last_owner.
- OWNn transitions:
  - req low and !rd_pending → IDLE.
  - req low and rd_pending → DRAINn.
  - DRAINn → IDLE when rd_pending clears.
- After IDLE, there is always ≥1 IDLE cycle with both grants low before the next grant. No back-to-back handover.
- Forwarding (owner in OWNn/DRAINn):
  - mN_rd_en/addr → s_rd_en/addr, 1-cycle latency.
  - mN_wr_en/addr/data → s_wr_*, 1-cycle latency.
  - Simultaneous rd_en and wr_en from the owner are both forwarded in the same cycle.
- Non-owner strobe (rd_en or wr_en) is not forwarded; cmd_dropped pulses for 1 cycle. An owner strobe in the same cycle is still forwarded.
- Read tracking:
  - A forwarded read sets rd_pending.
  - Masters issue at most one outstanding read; a new owner rd_en while rd_pending is forwarded and does not count twice.
  - s_rd_valid while rd_pending → owner's mN_rd_valid=1, mN_rd_data=s_rd_data one cycle later; clears rd_pending.
  - The non-owner's rd_valid is always 0.
- Timeout:
  - Counter resets on each forwarded read and increments while rd_pending.
  - At TIMEOUT_CYCLES-1 with no s_rd_valid: owner gets rd_valid=1, rd_data=8'hFF; rd_timeout pulses; rd_pending clears.
  - s_rd_valid in that same cycle takes precedence: real data, no timeout.
- s_rd_valid when !rd_pending (late or after timeout) → stray_valid pulse, nothing routed.
- Reset mid-transaction: state returns to IDLE immediately; in-flight slave responses arriving after reset are reported as stray_valid only.

Test Plan:
- M0 alone: req0=1, rd_en addr 0x0010, slave answers 0x5A after 3 cycles → grant0 1 cycle after req; s_rd_addr=0x0010 one cycle after rd_en; m0_rd_data=0x5A one cycle after s_rd_valid; grant1 never high.
- Both req in the same cycle from reset → M0 granted. M0 releases → 1 IDLE cycle, then M1 granted. Both re-request → M0 granted again (alternation).
- M1 holds req while M0 owns; M1 pulses wr_en addr 0x0100 data 0x33 → no s_wr_en, cmd_dropped=1 for 1 cycle. M0's write 0x0200/0xAA in the same cycle is forwarded.
- M0 drops req with a read pending → state DRAIN0, grant0 stays high until s_rd_valid, then IDLE; M1 granted only after that.
- Slave never answers with TIMEOUT_CYCLES=16 → m0_rd_valid with 0xFF and rd_timeout 16 cycles after the read is forwarded. A later s_rd_valid gives stray_valid=1 and no m0_rd_valid.
- rst_n low for 1 cycle during an M1 read → all grants/strobes 0 the next cycle. The slave's subsequent rd_valid gives stray_valid only.
